ysyx_23060075_lsu: RTL and testbench
====================================

Name: ysyx_23060075_lsu

Overview:
- Multi-cycle load/store unit. It is the responder for the control unit's memory-request outputs (mem_r_en, mem_w_en, mem_mask) and the funct3 field.
- Converts a held core request into a word-aligned valid/ready bus transaction with byte strobes, and returns aligned, sign- or zero-extended load data.
- lsu_done tells the core when to advance the PC.
- Sits between the execute stage (alu_result as address, rs2 as store data) and the data-memory bus.

Parameters:
- RESP_TIMEOUT, 16'd255: maximum cycles waiting in RESP before abort with error; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_r_en  input  1  load request, held by core until lsu_done
- mem_w_en  input  1  store request, held by core until lsu_done
- mem_mask  input  4  size: 0001 byte, 0011 half, 1111 word
- funct3  input  3  bit 2 = 1 means unsigned load (lbu/lhu)
- addr  input  32  byte address
- wdata  input  32  store data, LSB-aligned
- lsu_rdata  output  32  extended load result, valid while lsu_done = 1
- lsu_done  output  1  one-cycle completion pulse
- lsu_busy  output  1  state != IDLE
- lsu_err  output  1  bus error or timeout, valid with lsu_done
- lsu_misalign  output  1  misaligned access, valid with lsu_done
- req_valid  output  1  bus request valid
- req_ready  input  1  bus accepts request
- req_wen  output  1  1 = write
- req_addr  output  32  {addr[31:2], 2'b00}
- req_wdata  output  32  lane-shifted store data
- req_wstrb  output  4  byte strobes, 0000 on reads
- resp_valid  input  1  bus response valid
- resp_ready  output  1  LSU accepts response
- resp_rdata  input  32  raw bus word
- resp_err  input  1  bus error flag

Behaviour:
- States: IDLE, REQ, RESP, DONE. rst forces IDLE on the next edge from any state; this aborts any in-flight access.
- Reset values: req_valid = 0, lsu_done = 0, lsu_busy = 0, lsu_err = 0, lsu_misalign = 0, lsu_rdata = 0, resp_ready = 1.
- IDLE, resp_ready = 1: any resp_valid is accepted and discarded. This drains stale responses after a reset.
- IDLE, transition on (mem_r_en | mem_w_en):
  - Latch addr, wdata, size, funct3[2], and wen = mem_w_en. If both enables are high, the write wins.
  - If misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): go to DONE with misalign = 1, err = 0, rdata = 0. No bus transaction occurs.
  - Otherwise go to REQ.
- mem_mask decoding: any value other than 0001 or 0011 is treated as word.
- REQ:
  - req_valid = 1; req_addr, req_wen, req_wdata, req_wstrb are driven from the latched values and held stable until the handshake.
  - req_wdata = wdata << (8*addr[1:0]).
  - req_wstrb = mask << addr[1:0] on writes, 0000 on reads.
  - resp_ready = 0.
  - On req_valid & req_ready: go to RESP and clear the timeout counter. There is no timeout in REQ.
- RESP:
  - resp_ready = 1, req_valid = 0. The 16-bit counter increments each cycle.
  - On resp_valid: latch err = resp_err. For reads, shift = resp_rdata >> (8*addr[1:0]); byte/half are sign-extended from bit 7/15, or zero-extended if funct3[2] = 1; word is passed unchanged. For writes, or when resp_err = 1, rdata = 0. Go to DONE.
  - Else if RESP_TIMEOUT != 0 and counter == RESP_TIMEOUT - 1: go to DONE with err = 1, rdata = 0.
  - resp_valid in the timeout cycle wins over the timeout.
- DONE:
  - lsu_done = 1 for exactly one cycle, with lsu_rdata, lsu_err, lsu_misalign valid. Go to IDLE unconditionally.
  - These three outputs are 0 outside DONE.
- Latency with a zero-wait bus: enable seen in cycle 0, REQ in cycle 1, RESP in cycle 2, lsu_done in cycle 3. A misaligned access gives lsu_done in cycle 1.
- Back-to-back: IDLE samples the next instruction's enables one cycle after DONE. The core must update its enables on the lsu_done edge.
- lsu_busy = 1 in REQ, RESP and DONE.

Test Plan:
- lb: addr = 0x80000003, resp_rdata = 0x80AABBCC, funct3 = 000, zero-wait bus -> req_addr = 0x80000000, req_wstrb = 0000, lsu_done in cycle 3, lsu_rdata = 0xFFFFFF80. Same with funct3 = 100 -> 0x00000080.
- sh: addr = 0x80000002, wdata = 0x1234ABCD, mask = 0011 -> req_wdata = 0xABCD0000, req_wstrb = 1100, req_wen = 1, lsu_rdata = 0.
- Misaligned lw at addr 0x80000001 -> req_valid never asserts, lsu_done in cycle 1, lsu_misalign = 1, lsu_rdata = 0.
- Backpressure: req_ready low for 5 cycles, then resp_valid 3 cycles after the handshake -> req_valid/req_addr stable throughout, lsu_done exactly one cycle, lh of 0x0000F00D at offset 0 -> 0xFFFFF00D.
- RESP_TIMEOUT = 4, no resp_valid -> lsu_done 4 cycles after entering RESP, lsu_err = 1. Variant with resp_err = 1 on the first response -> lsu_err = 1, lsu_rdata = 0.
- rst asserted in RESP, then a stale resp_valid in the cycle after rst releases -> state IDLE, response consumed (resp_ready = 1), no lsu_done. A following lw completes normally.

Source files
------------

// File: rtl/ysyx_23060075_lsu.sv
// ysyx_23060075_lsu: multi-cycle load/store unit bridging held core memory
// requests onto a word-aligned valid/ready data bus.
module ysyx_23060075_lsu #(
  parameter logic [15:0] RESP_TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [3:0]  mem_mask,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic        lsu_err,
  output logic        lsu_misalign,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  mask_q;
  logic        uns_q, wen_q, err_q, mis_q;
  logic [15:0] cnt_q;

  logic        req_en, misalign, timeout_hit;
  logic [3:0]  mask_n;
  logic [31:0] shifted, load_val;
  logic        unused_f3;

  // request decode: unknown size encodings collapse to word
  always_comb begin
    req_en    = mem_r_en | mem_w_en;
    mask_n    = (mem_mask == 4'b0001) ? 4'b0001 :
                (mem_mask == 4'b0011) ? 4'b0011 : 4'b1111;
    misalign  = ((mask_n == 4'b0011) && addr[0]) ||
                ((mask_n == 4'b1111) && (addr[1:0] != 2'b00));
    unused_f3 = ^funct3[1:0];
  end

  always_comb begin
    timeout_hit = (RESP_TIMEOUT != 16'd0) && (cnt_q == RESP_TIMEOUT - 16'd1);
    shifted     = resp_rdata >> {addr_q[1:0], 3'b000};
    case (mask_q)
      4'b0001: load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      4'b0011: load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_en) state_d = misalign ? DONE : REQ;
      REQ:     if (req_ready) state_d = RESP;
      RESP:    if (resp_valid || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_en) begin
          addr_q  <= addr;
          wdata_q <= wdata;
          mask_q  <= mask_n;
          uns_q   <= funct3[2];
          wen_q   <= mem_w_en;
          mis_q   <= misalign;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        REQ: if (req_ready) cnt_q <= '0;
        RESP: begin
          cnt_q <= cnt_q + 16'd1;
          // a response arriving in the timeout cycle takes priority
          if (resp_valid) begin
            err_q   <= resp_err;
            rdata_q <= (wen_q || resp_err) ? '0 : load_val;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_valid    = (state_q == REQ);
    resp_ready   = (state_q == IDLE) || (state_q == RESP);
    lsu_busy     = (state_q != IDLE);
    lsu_done     = (state_q == DONE);
    lsu_rdata    = (state_q == DONE) ? rdata_q : '0;
    lsu_err      = (state_q == DONE) && err_q;
    lsu_misalign = (state_q == DONE) && mis_q;
    req_wen      = wen_q;
    req_addr     = {addr_q[31:2], 2'b00};
    req_wdata    = wdata_q << {addr_q[1:0], 3'b000};
    req_wstrb    = wen_q ? (mask_q << addr_q[1:0]) : 4'b0000;
  end

endmodule

// File: tb/tb_ysyx_23060075_lsu.sv
module tb_ysyx_23060075_lsu;

  logic        clk, rst;
  logic        mem_r_en, mem_w_en;
  logic [3:0]  mem_mask;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done, lsu_busy, lsu_err, lsu_misalign;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  ysyx_23060075_lsu #(.RESP_TIMEOUT(16'd4)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_mask(mem_mask), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_busy(lsu_busy),
    .lsu_err(lsu_err), .lsu_misalign(lsu_misalign),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          r, w;
    logic [3:0]  mask;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, bus_rdata;
    bit          bus_err;
    int unsigned req_lat, resp_lat;
    bit          no_resp;
    logic [31:0] exp_rdata;
    bit          exp_err, exp_mis;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    int unsigned exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit w, logic [3:0] mask, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] brd, bit berr,
                              int unsigned rql, int unsigned rsl, bit nr,
                              logic [31:0] erd, bit eerr, bit emis,
                              logic [3:0] ews, logic [31:0] ewd, int unsigned elat);
    vec_t v;
    v.r = r; v.w = w; v.mask = mask; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.bus_rdata = brd; v.bus_err = berr; v.req_lat = rql; v.resp_lat = rsl; v.no_resp = nr;
    v.exp_rdata = erd; v.exp_err = eerr; v.exp_mis = emis;
    v.exp_wstrb = ews; v.exp_wdata = ewd; v.exp_lat = elat;
    return v;
  endfunction

  // reference: access size in bytes, byte offset, plain arithmetic extension
  function automatic vec_t model(vec_t v);
    int unsigned n, off;
    longint unsigned one, val, wd;
    one = 1;
    n   = (v.mask == 4'b0001) ? 1 : (v.mask == 4'b0011) ? 2 : 4;
    off = v.addr % 4;
    v.exp_mis   = (v.addr % n) != 0;
    v.exp_err   = !v.exp_mis && (v.no_resp || v.bus_err);
    v.exp_wstrb = v.w ? 4'(((one << n) - 1) << off) : 4'b0000;
    wd          = longint'(v.wdata) << (8 * off);
    v.exp_wdata = wd[31:0];
    if (v.exp_mis || v.w || v.exp_err) v.exp_rdata = 32'h0;
    else begin
      val = (longint'(v.bus_rdata) >> (8 * off)) % (one << (8 * n));
      if (n < 4 && !v.f3[2] && val >= (one << (8 * n - 1))) val = val - (one << (8 * n));
      v.exp_rdata = val[31:0];
    end
    if (v.exp_mis)      v.exp_lat = 1;
    else if (v.no_resp) v.exp_lat = 6 + v.req_lat;
    else                v.exp_lat = 3 + v.req_lat + v.resp_lat;
    return v;
  endfunction

  // drives one access from cycle 0 and plays the bus side until lsu_done
  task automatic run(input vec_t v, input string nm);
    bit hs = 0, in_resp = 0, seen_req = 0, got_done = 0;
    int unsigned rw = 0, sw = 0;
    mem_r_en = v.r; mem_w_en = v.w; mem_mask = v.mask; funct3 = v.f3;
    addr = v.addr; wdata = v.wdata;
    for (int unsigned c = 1; c <= 60 && !got_done; c++) begin
      @(posedge clk); #1;
      req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = $urandom;
      if (hs) begin in_resp = 1; hs = 0; end
      if (lsu_done) begin
        got_done = 1;
        chk({nm, ".rdata"}, lsu_rdata, v.exp_rdata);
        chk({nm, ".err"}, 32'(lsu_err), 32'(v.exp_err));
        chk({nm, ".mis"}, 32'(lsu_misalign), 32'(v.exp_mis));
        chk({nm, ".lat"}, c, v.exp_lat);
        chk({nm, ".busy"}, 32'(lsu_busy), 32'd1);
        mem_r_en = 1'b0; mem_w_en = 1'b0;
      end else begin
        chk({nm, ".quiet"}, {lsu_rdata[31:2], lsu_err, lsu_misalign}, 32'h0);
        if (req_valid) begin
          seen_req = 1;
          chk({nm, ".req_addr"}, req_addr, v.addr & 32'hFFFF_FFFC);
          chk({nm, ".req_wen"}, 32'(req_wen), 32'(v.w));
          chk({nm, ".req_wstrb"}, 32'(req_wstrb), 32'(v.exp_wstrb));
          if (v.w) chk({nm, ".req_wdata"}, req_wdata, v.exp_wdata);
          chk({nm, ".rr_in_req"}, 32'(resp_ready), 32'd0);
          if (rw == v.req_lat) begin req_ready = 1'b1; hs = 1; end
          rw++;
        end else if (in_resp) begin
          if (!v.no_resp && sw == v.resp_lat) begin
            resp_valid = 1'b1; resp_rdata = v.bus_rdata; resp_err = v.bus_err;
          end
          sw++;
        end
      end
    end
    if (!got_done) chk({nm, ".done_seen"}, 32'd0, 32'd1);
    chk({nm, ".bus_used"}, 32'(seen_req), 32'(!v.exp_mis));
    @(posedge clk); #1;
    chk({nm, ".pulse"}, 32'(lsu_done), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b1; mem_r_en = 0; mem_w_en = 0; mem_mask = 0; funct3 = 0; addr = 0; wdata = 0;
    req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {req_valid, lsu_done, lsu_busy, lsu_err, lsu_misalign}, 32'h0);
    chk("reset.rdata", lsu_rdata, 32'h0);
    chk("reset.resp_ready", 32'(resp_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    //        r w mask     f3      addr          wdata         bus_rdata     err rq rs nr  exp_rdata   eerr emis wstrb    wdata        lat
    tbl.push_back(mk(1,0,4'b0001,3'b000,32'h8000_0003,32'h0,       32'h80AA_BBCC,0, 0,0,0, 32'hFFFF_FF80,0,0,4'b0000,32'h0,        3));
    tbl.push_back(mk(1,0,4'b0001,3'b100,32'h8000_0003,32'h0,       32'h80AA_BBCC,0, 0,0,0, 32'h0000_0080,0,0,4'b0000,32'h0,        3));
    tbl.push_back(mk(0,1,4'b0011,3'b001,32'h8000_0002,32'h1234_ABCD,32'hDEAD_BEEF,0,0,0,0, 32'h0,        0,0,4'b1100,32'hABCD_0000,3));
    tbl.push_back(mk(1,0,4'b1111,3'b010,32'h8000_0001,32'h0,       32'h0,        0, 0,0,0, 32'h0,        0,1,4'b0000,32'h0,        1));
    tbl.push_back(mk(1,0,4'b0011,3'b001,32'h8000_0000,32'h0,       32'h0000_F00D,0, 5,3,0, 32'hFFFF_F00D,0,0,4'b0000,32'h0,        11));
    tbl.push_back(mk(1,0,4'b1111,3'b010,32'h8000_0010,32'h0,       32'h0,        0, 0,0,1, 32'h0,        1,0,4'b0000,32'h0,        6));
    tbl.push_back(mk(1,0,4'b1111,3'b010,32'h8000_0010,32'h0,       32'h1234_5678,1, 0,0,0, 32'h0,        1,0,4'b0000,32'h0,        3));
    tbl.push_back(mk(1,1,4'b1111,3'b010,32'h8000_0004,32'hCAFE_BABE,32'h1111_1111,0,0,1,0, 32'h0,        0,0,4'b1111,32'hCAFE_BABE,4));
    tbl.push_back(mk(1,0,4'b0101,3'b010,32'h0000_0100,32'h0,       32'h89AB_CDEF,0, 1,0,0, 32'h89AB_CDEF,0,0,4'b0000,32'h0,        4));
    tbl.push_back(mk(1,0,4'b0011,3'b001,32'h8000_0002,32'h0,       32'h8001_0000,0, 0,3,0, 32'hFFFF_8001,0,0,4'b0000,32'h0,        6));
    tbl.push_back(mk(0,1,4'b0011,3'b001,32'h8000_0003,32'h5555_5555,32'h0,       0, 0,0,0, 32'h0,        0,1,4'b0000,32'h0,        1));
    tbl.push_back(mk(0,1,4'b0001,3'b000,32'h8000_0001,32'h0000_00A5,32'h0,       0, 2,2,0, 32'h0,        0,0,4'b0010,32'h0000_A500,7));

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // reset while waiting for a response, then a stale response after release
    mem_r_en = 1; mem_mask = 4'b1111; funct3 = 3'b010; addr = 32'h8000_0020;
    @(posedge clk); #1;
    chk("rstseq.req", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk("rstseq.in_resp", {29'b0, resp_ready, lsu_busy, req_valid}, 32'h6);
    rst = 1'b1; mem_r_en = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstseq.idle_busy", 32'(lsu_busy), 32'd0);
    chk("rstseq.idle_rr", 32'(resp_ready), 32'd1);
    resp_valid = 1'b1; resp_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      resp_valid = 1'b0;
      chk($sformatf("rstseq.no_done%0d", i), {30'b0, lsu_done, lsu_busy}, 32'h0);
    end
    run(mk(1,0,4'b1111,3'b010,32'h8000_0024,32'h0,32'h7654_3210,0,0,0,0,
           32'h7654_3210,0,0,4'b0000,32'h0,3), "after_rst");

    // randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      int unsigned m;
      v.r = $urandom_range(0, 1);
      v.w = $urandom_range(0, 1);
      if (!v.r && !v.w) v.r = 1;
      m = $urandom_range(0, 3);
      v.mask = (m == 0) ? 4'b0001 : (m == 1) ? 4'b0011 : (m == 2) ? 4'b1111 : 4'($urandom);
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.bus_rdata = $urandom;
      v.bus_err = ($urandom_range(0, 7) == 0);
      v.req_lat = $urandom_range(0, 3);
      v.resp_lat = $urandom_range(0, 3);
      v.no_resp = ($urandom_range(0, 9) == 0);
      run(model(v), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
